// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider: FSM state encoding and default width.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents:
//   DIV_WIDTH_DEF  default operand/result width
//   div_state_e    divider FSM states (IDLE, RUN, FIX)
package div_pkg;

  // Default operand/result width used by seq_divider and div_step.
  localparam int DIV_WIDTH_DEF = 32;

  // IDLE: waiting for start.
  // RUN : one restoring iteration per cycle, MSB first.
  // FIX : sign correction and result load; done pulses on this edge.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration: shift in one dividend bit, subtract if it fits.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when to register the result.
//
// Ports:
//   rem_i  partial remainder before this step (WIDTH+1 bits)
//   div_i  divisor magnitude
//   bit_i  next dividend bit, MSB first
//   rem_o  partial remainder after this step
//   q_o    quotient bit produced by this step
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEF
) (
  input  logic [WIDTH:0]   rem_i,
  input  logic [WIDTH-1:0] div_i,
  input  logic             bit_i,
  output logic [WIDTH:0]   rem_o,
  output logic             q_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] div_ext;

  // The shifted remainder is compared at WIDTH+1 bits so a divisor with its MSB set
  // is never compared against a truncated value.
  assign shifted = {rem_i[WIDTH-1:0], bit_i};
  assign div_ext = {1'b0, div_i};

  // If the incoming remainder already had its top bit set, the shifted value is at least
  // 2^(WIDTH+1) and therefore exceeds any divisor; the modular subtraction below still
  // yields the exact remainder because it is known to be smaller than the divisor.
  assign q_o   = rem_i[WIDTH] | (shifted >= div_ext);
  assign rem_o = q_o ? (shifted - div_ext) : shifted;

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider, signed or unsigned, producing quotient (lo) and remainder (hi).
// Latency: done WIDTH+1 cycles after accept; 1 cycle after accept on divide-by-zero.
// Backpressure: start is only sampled in IDLE; starts while busy are silently ignored.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   start      request; sampled only in IDLE together with is_signed/dividend/divisor
//   is_signed  two's-complement operands when 1 (ignored when SIGNED_EN=0)
//   dividend   numerator
//   divisor    denominator
//   busy       high from the cycle after accept until done
//   done       one-cycle pulse when lo/hi/div_zero/overflow are valid
//   div_zero   divisor was zero (lo=all ones, hi=dividend); held until next accept
//   overflow   signed MIN / -1 (lo=MIN, hi=0); held until next accept
//   lo         quotient, held until the next done
//   hi         remainder, held until the next done
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH     = DIV_WIDTH_DEF,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic             overflow,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  // FSM and datapath state
  div_state_e       state_q;
  logic [CW-1:0]    cnt_q;      // remaining RUN iterations minus one
  logic [WIDTH:0]   rem_q;      // partial remainder
  logic [WIDTH-1:0] quo_q;      // dividend bits shift out the top, quotient bits shift in the bottom
  logic [WIDTH-1:0] dvs_q;      // divisor magnitude
  logic             qneg_q;     // quotient must be negated in FIX
  logic             rneg_q;     // remainder must be negated in FIX
  logic             ovf_pend_q; // MIN / -1 detected at accept, reported at done
  logic             dz_pend_q;  // divide-by-zero detected at accept, reported at done

  // Registered outputs
  logic             busy_q;
  logic             done_q;
  logic             div_zero_q;
  logic             overflow_q;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH-1:0] hi_q;

  // Operand conditioning for the accept cycle
  logic             sgn_mode;
  logic             dvd_neg;
  logic             dvs_neg;
  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dvs_mag;
  logic             dvs_zero;
  logic             ovf_det;

  // Restoring step outputs
  logic [WIDTH:0]   step_rem_d;
  logic             step_q_d;

  assign sgn_mode = SIGNED_EN & is_signed;
  assign dvd_neg  = sgn_mode & dividend[WIDTH-1];
  assign dvs_neg  = sgn_mode & divisor[WIDTH-1];

  // Magnitude of MIN is 2^(WIDTH-1), which is exactly MIN's bit pattern read as unsigned,
  // so the unsigned datapath handles it without an extra bit.
  assign dvd_mag  = dvd_neg ? (-dividend) : dividend;
  assign dvs_mag  = dvs_neg ? (-divisor)  : divisor;
  assign dvs_zero = (divisor == '0);
  assign ovf_det  = sgn_mode && (dividend == MIN_VAL) && (divisor == '1);

  div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem_i (rem_q),
    .div_i (dvs_q),
    .bit_i (quo_q[WIDTH-1]),
    .rem_o (step_rem_d),
    .q_o   (step_q_d)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      dvs_q      <= '0;
      qneg_q     <= 1'b0;
      rneg_q     <= 1'b0;
      ovf_pend_q <= 1'b0;
      dz_pend_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      overflow_q <= 1'b0;
      lo_q       <= '0;
      hi_q       <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            busy_q     <= 1'b1;
            div_zero_q <= 1'b0;
            overflow_q <= 1'b0;
            rneg_q     <= dvd_neg;
            ovf_pend_q <= ovf_det;
            cnt_q      <= CW'(WIDTH - 1);
            if (dvs_zero) begin
              // Skip RUN: preload quotient all ones and remainder = |dividend|, so the
              // ordinary FIX sign correction restores hi to the original dividend.
              quo_q     <= '1;
              rem_q     <= {1'b0, dvd_mag};
              qneg_q    <= 1'b0;
              dz_pend_q <= 1'b1;
              state_q   <= FIX;
            end else begin
              quo_q     <= dvd_mag;
              dvs_q     <= dvs_mag;
              rem_q     <= '0;
              qneg_q    <= dvd_neg ^ dvs_neg;
              dz_pend_q <= 1'b0;
              state_q   <= RUN;
            end
          end
        end

        RUN: begin
          rem_q <= step_rem_d;
          quo_q <= {quo_q[WIDTH-2:0], step_q_d};
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == '0) begin
            state_q <= FIX;
          end
        end

        FIX: begin
          lo_q       <= qneg_q ? (-quo_q) : quo_q;
          hi_q       <= rneg_q ? (-rem_q[WIDTH-1:0]) : rem_q[WIDTH-1:0];
          div_zero_q <= dz_pend_q;
          overflow_q <= ovf_pend_q;
          done_q     <= 1'b1;
          busy_q     <= 1'b0;
          state_q    <= IDLE;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = div_zero_q;
  assign overflow = overflow_q;
  assign lo       = lo_q;
  assign hi       = hi_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed and randomized checks of seq_divider at WIDTH=32 and WIDTH=8.
// Expected results are queued when a request is driven and popped when done is seen.
module tb_seq_divider;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // WIDTH=32 instance
  logic        s32, sg32;
  logic [31:0] a32, b32;
  logic        busy32, done32, dz32, ov32;
  logic [31:0] lo32, hi32;

  seq_divider #(.WIDTH(32), .SIGNED_EN(1'b1)) dut32 (
    .clk       (clk),
    .reset     (reset),
    .start     (s32),
    .is_signed (sg32),
    .dividend  (a32),
    .divisor   (b32),
    .busy      (busy32),
    .done      (done32),
    .div_zero  (dz32),
    .overflow  (ov32),
    .lo        (lo32),
    .hi        (hi32)
  );

  // WIDTH=8 instance
  logic       s8, sg8;
  logic [7:0] a8, b8;
  logic       busy8, done8, dz8, ov8;
  logic [7:0] lo8, hi8;

  seq_divider #(.WIDTH(8), .SIGNED_EN(1'b1)) dut8 (
    .clk       (clk),
    .reset     (reset),
    .start     (s8),
    .is_signed (sg8),
    .dividend  (a8),
    .divisor   (b8),
    .busy      (busy8),
    .done      (done8),
    .div_zero  (dz8),
    .overflow  (ov8),
    .lo        (lo8),
    .hi        (hi8)
  );

  typedef struct packed {
    logic [31:0] lo;
    logic [31:0] hi;
    logic        dz;
    logic        ov;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] l, input logic [31:0] h,
                              input logic dz, input logic ov);
    exp_t e;
    e.lo = l;
    e.hi = h;
    e.dz = dz;
    e.ov = ov;
    return e;
  endfunction

  // Reference model for the 8-bit instance, built on the simulator's own arithmetic.
  function automatic exp_t model8(input logic [7:0] a, input logic [7:0] b, input logic sg);
    exp_t e;
    int   sa, sb, q, r;
    e = '0;
    if (b == 8'h00) begin
      e.lo = 32'h0000_00FF;
      e.hi = {24'h0, a};
      e.dz = 1'b1;
    end else if (sg && a == 8'h80 && b == 8'hFF) begin
      e.lo = 32'h0000_0080;
      e.hi = 32'h0;
      e.ov = 1'b1;
    end else if (sg) begin
      sa   = int'($signed(a));
      sb   = int'($signed(b));
      q    = sa / sb;
      r    = sa % sb;
      e.lo = {24'h0, q[7:0]};
      e.hi = {24'h0, r[7:0]};
    end else begin
      e.lo = {24'h0, a / b};
      e.hi = {24'h0, a % b};
    end
    return e;
  endfunction

  // Drives one 32-bit request at the current time (must be between edges, DUT idle),
  // then checks accept side effects, latency, results and output hold.
  task automatic run32(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic sg, input exp_t e, input int exp_lat);
    exp_t got;
    int   lat;
    bit   seen;
    logic [31:0] lo_seen;
    sb_q.push_back(e);
    s32 = 1'b1; a32 = a; b32 = b; sg32 = sg;
    @(posedge clk); #1;
    s32 = 1'b0; a32 = $urandom; b32 = $urandom; sg32 = 1'($urandom);
    check({tag, ".busy"}, 64'(busy32), 64'(1));
    check({tag, ".flags_clr"}, 64'({dz32, ov32}), 64'(0));
    seen = 1'b0;
    lat  = 0;
    for (int c = 1; c <= 100; c++) begin
      @(posedge clk); #1;
      if (done32) begin
        lat  = c;
        seen = 1'b1;
        break;
      end
    end
    check({tag, ".latency"}, 64'(lat), 64'(exp_lat));
    got = sb_q.pop_front();
    if (seen) begin
      check({tag, ".lo"}, 64'(lo32), 64'(got.lo));
      check({tag, ".hi"}, 64'(hi32), 64'(got.hi));
      check({tag, ".div_zero"}, 64'(dz32), 64'(got.dz));
      check({tag, ".overflow"}, 64'(ov32), 64'(got.ov));
      lo_seen = lo32;
      @(posedge clk); #1;
      check({tag, ".done_pulse"}, 64'(done32), 64'(0));
      check({tag, ".lo_hold"}, 64'(lo32), 64'(lo_seen));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".busy32"}, 64'(busy32), 64'(0));
    check({tag, ".done32"}, 64'(done32), 64'(0));
    check({tag, ".flags32"}, 64'({dz32, ov32}), 64'(0));
    check({tag, ".lo32"}, 64'(lo32), 64'(0));
    check({tag, ".hi32"}, 64'(hi32), 64'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, observed no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e8, got8;
    int   lat8, exp_lat8, pick;
    bit   seen8;
    logic [7:0] na, nb;
    logic       nsg;

    reset = 1'b1;
    s32 = 1'b0; sg32 = 1'b0; a32 = '0; b32 = '0;
    s8  = 1'b0; sg8  = 1'b0; a8  = '0; b8  = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    check("reset.busy8", 64'(busy8), 64'(0));
    check("reset.out8", 64'({done8, dz8, ov8, lo8, hi8}), 64'(0));

    // Start in the very first cycle after reset deasserts.
    @(negedge clk);
    reset = 1'b0;
    run32("u100_7", 32'd100, 32'd7, 1'b0, mk(32'd14, 32'd2, 1'b0, 1'b0), 33);
    run32("s-7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, mk(32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b0), 33);
    run32("s7_-2", 32'd7, 32'hFFFF_FFFE, 1'b1, mk(32'hFFFF_FFFD, 32'd1, 1'b0, 1'b0), 33);
    run32("u5_0", 32'd5, 32'd0, 1'b0, mk(32'hFFFF_FFFF, 32'd5, 1'b1, 1'b0), 1);
    run32("smin_-1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, mk(32'h8000_0000, 32'd0, 1'b0, 1'b1), 33);
    run32("umin_ff", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, mk(32'd0, 32'h8000_0000, 1'b0, 1'b0), 33);
    run32("s-5_0", 32'hFFFF_FFFB, 32'd0, 1'b1, mk(32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1, 1'b0), 1);
    run32("u_big", 32'hFFFF_FFFF, 32'h8000_0001, 1'b0, mk(32'd1, 32'h7FFF_FFFE, 1'b0, 1'b0), 33);

    // Abort an operation mid-RUN with reset.
    s32 = 1'b1; a32 = 32'd1000; b32 = 32'd3; sg32 = 1'b0;
    @(posedge clk); #1;
    s32 = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("abort");
    @(negedge clk);
    reset = 1'b0;
    run32("after_abort", 32'd1000, 32'd3, 1'b0, mk(32'd333, 32'd1, 1'b0, 1'b0), 33);

    // WIDTH=8: start held high, back-to-back random requests, junk operands while busy.
    s8 = 1'b1;
    na = 8'($urandom); nb = 8'($urandom); nsg = 1'($urandom);
    for (int i = 0; i < 1000; i++) begin
      if (i > 0) begin
        pick = $urandom_range(0, 15);
        na  = 8'($urandom);
        nb  = 8'($urandom);
        nsg = 1'($urandom);
        if (pick == 0) nb = 8'h00;
        else if (pick == 1) begin na = 8'h80; nb = 8'hFF; end
        else if (pick == 2) nb = 8'h01;
      end
      a8 = na; b8 = nb; sg8 = nsg;
      sb_q.push_back(model8(na, nb, nsg));
      exp_lat8 = (nb == 8'h00) ? 1 : 9;
      @(posedge clk); #1;
      check("w8.busy", 64'(busy8), 64'(1));
      a8 = 8'($urandom); b8 = 8'($urandom); sg8 = 1'($urandom);
      seen8 = 1'b0;
      lat8  = 0;
      for (int c = 1; c <= 30; c++) begin
        @(posedge clk); #1;
        if (done8) begin
          lat8  = c;
          seen8 = 1'b1;
          break;
        end
      end
      check("w8.latency", 64'(lat8), 64'(exp_lat8));
      got8 = sb_q.pop_front();
      if (seen8) begin
        check("w8.lo", 64'(lo8), 64'(got8.lo[7:0]));
        check("w8.hi", 64'(hi8), 64'(got8.hi[7:0]));
        check("w8.flags", 64'({dz8, ov8}), 64'({got8.dz, got8.ov}));
      end
    end
    s8 = 1'b0;
    @(posedge clk); #1;
    check("w8.done_pulse", 64'(done8), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
